cond_select_subtractor_pipe: RTL and testbench
==============================================

Name: cond_select_subtractor_pipe

Overview:
- Two-stage pipelined conditional-select subtractor: diff = a - b - bin, with borrow-out and signed-overflow flags.
- Valid/ready handshake on both sides, so it can sit in a streaming datapath that applies backpressure.
- Subtraction is computed as a + ~b + ~bin. Nibble-split carry-select is used: the low half resolves in stage 1 while both high-half candidates are precomputed, and stage 2 selects between them.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4.
- HALF = WIDTH/2 is derived (localparam, not overridable).

Ports:
- clk        input   1      rising-edge clock
- rst_n      input   1      synchronous reset, active-low
- a          input   WIDTH  minuend
- b          input   WIDTH  subtrahend
- bin        input   1      borrow-in (1 = subtract one more)
- in_valid   input   1      a/b/bin valid this cycle
- in_ready   output  1      block accepts input this cycle
- diff       output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout       output  1      borrow-out, unsigned a < b + bin
- ovf        output  1      two's-complement overflow
- out_valid  output  1      diff/bout/ovf valid
- out_ready  input   1      downstream accepts result

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage 1 register (s1_valid plus data), loaded on input transfer, using y = ~b and c0 = ~bin:
  - low half: lo_sum = a[HALF-1:0] + y[HALF-1:0] + c0, and carry lo_c.
  - both high-half candidates: hi_sum0/hi_c0 with carry-in 0, hi_sum1/hi_c1 with carry-in 1.
  - a[WIDTH-1] and b[WIDTH-1], kept for the overflow calculation.
- Stage 2 / output register (out_valid plus diff/bout/ovf), loaded from stage 1:
  - diff = {lo_c ? hi_sum1 : hi_sum0, lo_sum}
  - c_out = lo_c ? hi_c1 : hi_c0
  - bout = ~c_out
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)
- Latency: exactly 2 clk edges from input transfer to out_valid, when not stalled. Throughput is 1 result per cycle.
- Flow control:
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_adv (combinational, no bubble when downstream drains)
  - s1_valid next = input transfer ? 1 : (s2_adv ? 0 : s1_valid)
  - out_valid next = s2_adv ? 1 : (out_ready ? 0 : out_valid)
  - Stage 1 data updates only on input transfer. Output data updates only on s2_adv.
- Stall: while out_valid && !out_ready, diff/bout/ovf hold stable. Stage 1 holds its entry, and once stage 1 is full in_ready = 0.
- Simultaneous output transfer, s2_adv and input transfer in one cycle: all three occur. Order is preserved, with no loss or duplication.
- in_valid may be asserted while in_ready = 0. Data is not captured until handshake. The upstream must hold its values.
- Reset (rst_n = 0 at a clk edge), including mid-stream:
  - s1_valid = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0, all stage-1 data = 0.
  - In-flight operations are discarded.
  - in_ready reads 1 in the first cycle after reset is released.
- Wrap-around: diff is modulo 2^WIDTH.
  - Example: 0x00 - 0x00 - 1 = 0xFF, bout = 1.
- No X propagation: all registers have a reset value.

Test Plan:
- Reset: hold rst_n = 0 for 3 clk with in_valid = 1 -> out_valid = 0, diff = 0x00, bout = 0, ovf = 0. After release, in_ready = 1.
- Basic and low-half borrow crossing:
  - a=0x50, b=0x30, bin=0 -> 2 cycles later diff=0x20, bout=0, ovf=0.
  - a=0x10, b=0x01, bin=0 -> diff=0x0F, bout=0, ovf=0.
- Borrow and wrap:
  - a=0x10, b=0x20, bin=1 -> diff=0xEF, bout=1, ovf=0.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Overflow:
  - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
- Backpressure: stream 6 back-to-back operations (a=i*0x11, b=0x01) with out_ready=0 during cycles 3-6:
  - in_ready drops to 0 after 2 accepted entries.
  - diff holds stable while stalled.
  - All 6 results (0xFF, 0x10, 0x21, 0x32, 0x43, 0x54) emerge in order, each exactly once.
  - Full throughput resumes with out_ready=1.
- Reset mid-operation: accept 2 operations, assert rst_n=0 for 1 cycle before any output transfer -> out_valid=0 next cycle, and neither result ever appears.

Source files
------------

// File: rtl/cond_select_subtractor_pipe.sv
// Two-stage valid/ready subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// with a carry-select split (low half resolved in stage 1, high half selected in stage 2).
module cond_select_subtractor_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int HALF = WIDTH / 2;

    // Flow control
    logic in_xfer;
    logic s2_adv;
    logic s1_valid;

    // Stage 1 combinational precompute
    logic [WIDTH-1:0] y;
    logic             c0;
    logic [HALF:0]    lo_ext;
    logic [HALF:0]    hi0_ext;
    logic [HALF:0]    hi1_ext;

    // Stage 1 registers
    logic [HALF-1:0]  s1_lo_sum;
    logic             s1_lo_c;
    logic [HALF-1:0]  s1_hi_sum0;
    logic             s1_hi_c0;
    logic [HALF-1:0]  s1_hi_sum1;
    logic             s1_hi_c1;
    logic             s1_a_msb;
    logic             s1_b_msb;

    // Stage 2 combinational select
    logic [WIDTH-1:0] diff_nxt;
    logic             c_out;
    logic             ovf_nxt;

    always_comb begin
        s2_adv   = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_adv;
        in_xfer  = in_valid && in_ready;
    end

    always_comb begin
        y       = ~b;
        c0      = ~bin;
        lo_ext  = (HALF+1)'(a[HALF-1:0]) + (HALF+1)'(y[HALF-1:0]) + (HALF+1)'(c0);
        hi0_ext = (HALF+1)'(a[WIDTH-1:HALF]) + (HALF+1)'(y[WIDTH-1:HALF]);
        hi1_ext = (HALF+1)'(a[WIDTH-1:HALF]) + (HALF+1)'(y[WIDTH-1:HALF]) + (HALF+1)'(1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lo_sum  <= '0;
            s1_lo_c    <= 1'b0;
            s1_hi_sum0 <= '0;
            s1_hi_c0   <= 1'b0;
            s1_hi_sum1 <= '0;
            s1_hi_c1   <= 1'b0;
            s1_a_msb   <= 1'b0;
            s1_b_msb   <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid   <= 1'b1;
                s1_lo_sum  <= lo_ext[HALF-1:0];
                s1_lo_c    <= lo_ext[HALF];
                s1_hi_sum0 <= hi0_ext[HALF-1:0];
                s1_hi_c0   <= hi0_ext[HALF];
                s1_hi_sum1 <= hi1_ext[HALF-1:0];
                s1_hi_c1   <= hi1_ext[HALF];
                s1_a_msb   <= a[WIDTH-1];
                s1_b_msb   <= b[WIDTH-1];
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Carry out of a + ~b + ~bin is the inverse of the borrow.
    always_comb begin
        diff_nxt = {s1_lo_c ? s1_hi_sum1 : s1_hi_sum0, s1_lo_sum};
        c_out    = s1_lo_c ? s1_hi_c1 : s1_hi_c0;
        ovf_nxt  = (s1_a_msb != s1_b_msb) && (diff_nxt[WIDTH-1] != s1_a_msb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= 1'b1;
                diff      <= diff_nxt;
                bout      <= ~c_out;
                ovf       <= ovf_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cond_select_subtractor_pipe.sv
// Scoreboard bench for cond_select_subtractor_pipe: the driver queues expected
// results on input transfer, the monitor checks every presented output against them.
module tb_cond_select_subtractor_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   outs   = 0;

    cond_select_subtractor_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: true signed/unsigned results of a - b - bin.
    function automatic exp_t model(input int av, input int bv, input int cv);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        int   u;
        sa   = (av >= 128) ? av - 256 : av;
        sb   = (bv >= 128) ? bv - 256 : bv;
        r    = sa - sb - cv;
        u    = (av - bv - cv + 512) % 256;
        e.d  = u[7:0];
        e.bo = (av < bv + cv);
        e.ov = (r < -128) || (r > 127);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q[0];
                chk("diff", int'(diff), int'(e.d));
                chk("bout", int'(bout), int'(e.bo));
                chk("ovf", int'(ovf), int'(e.ov));
                if (out_ready) begin
                    void'(q.pop_front());
                    outs++;
                end
            end
        end
    end

    // Present one op from the next negedge until accepted; returns at the following negedge with in_valid low.
    task automatic send(input int av, input int bv, input int cv);
        bit done;
        done = 0;
        @(negedge clk);
        a = av[7:0]; b = bv[7:0]; bin = cv[0]; in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            if (in_ready) begin
                q.push_back(model(av, bv, cv));
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int vec[7][3] = '{'{8'h50, 8'h30, 0}, '{8'h10, 8'h01, 0}, '{8'h10, 8'h20, 1},
                          '{8'h00, 8'h00, 1}, '{8'h80, 8'h01, 0}, '{8'h7F, 8'hFF, 0},
                          '{8'h00, 8'h00, 0}};
        int idx;
        int k;
        bit pend;
        int ra;
        int rb;
        int rc;

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h55; b = 8'h22; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_ovf", int'(ovf), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        // Latency: accepted at edge 1, visible after edge 2
        send(vec[0][0], vec[0][1], vec[0][2]);
        #1;
        chk("latency_edge1", int'(out_valid), 0);
        @(negedge clk);
        #1;
        chk("latency_edge2", int'(out_valid), 1);
        drain(20);

        for (int i = 1; i < 7; i++) send(vec[i][0], vec[i][1], vec[i][2]);
        drain(20);

        // Backpressure: 6 back-to-back ops, out_ready low in cycles 3..6
        idx = 0;
        for (k = 1; k < 60 && (idx < 6 || q.size() != 0); k++) begin
            @(negedge clk);
            out_ready = !(k >= 3 && k <= 6);
            in_valid  = (idx < 6);
            a = 8'(idx * 8'h11); b = 8'h01; bin = 1'b0;
            #1;
            if (in_valid && !in_ready) chk("full_when_not_ready", q.size(), 2);
            if (in_valid && k >= 7) chk("resume_throughput", int'(in_ready), 1);
            if (in_valid && in_ready) begin
                q.push_back(model(idx * 17, 1, 0));
                idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_sent", idx, 6);
        drain(20);

        // Random traffic with random backpressure
        pend = 0; idx = 0; ra = 0; rb = 0; rc = 0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!pend) begin
                if ($urandom_range(0, 9) < 7) begin
                    ra = int'($urandom_range(0, 255));
                    rb = int'($urandom_range(0, 255));
                    rc = int'($urandom_range(0, 1));
                    a = ra[7:0]; b = rb[7:0]; bin = rc[0];
                    in_valid = 1'b1; pend = 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && !in_ready) chk("rand_full_when_not_ready", q.size(), 2);
            if (in_valid && in_ready) begin
                q.push_back(model(ra, rb, rc));
                pend = 0;
                idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        drain(20);

        // Reset while two ops are in flight: neither may ever appear
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h33, 8'h11, 0);
        send(8'h44, 8'h11, 0);
        chk("mid_rst_inflight", q.size(), 2);
        rst_n = 1'b0;
        q.delete();
        idx = outs;
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        chk("mid_rst_no_outputs", outs - idx, 0);
        chk("mid_rst_idle", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
